// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port controller.
// Holds default widths, the register count and helper widths for the
// packed per-requester buses (requester i occupies slice i, LSB first).
package wb_pkg;

  localparam int NREQ_DEF = 3;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int NREG     = 32;

  localparam int RD_BUS_W_DEF   = NREQ_DEF * AW_DEF;
  localparam int DATA_BUS_W_DEF = NREQ_DEF * XLEN_DEF;

endpackage

// File: rtl/wb_arbiter.sv
// Grant generator for the shared register-file write port.
// Build option WB_RR_ARB_EN: round-robin with a pointer register naming the
// highest-priority requester. Without it: fixed priority, lowest index wins,
// and the module is purely combinational (no clock/reset ports).
// Ports:
//   clk, rst_n   (WB_RR_ARB_EN only) clock and async active-low reset
//   req_valid    per-requester write pending
//   grant        one-hot grant, all zero when nothing is valid
module wb_arbiter #(
  parameter int NREQ = 3
) (
`ifdef WB_RR_ARB_EN
  input  logic            clk,
  input  logic            rst_n,
`endif
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant
);

`ifdef WB_RR_ARB_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

  // Scan from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    int   idx;
    logic found;
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end
`else
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/wb_port_ctrl.sv
// Write-port controller for the 32x32 register file.
// Arbitrates NREQ writeback requesters onto the single write port, registers
// the accepted (rd, data) pair for the commit cycle, and keeps a busy
// scoreboard of destinations with writes outstanding.
// Build option WB_RR_ARB_EN selects round-robin arbitration (see wb_arbiter);
// default is fixed priority.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/rd/data     packed requester buses, requester i at the LSBs
//   req_ready             per-requester accept (0 while in reset)
//   wren/rd_addr/reg_data registered register-file write port
//   iss_valid/iss_rd      issue marks a destination busy
//   rs_addr1/2, busy_rs1/2 combinational busy query of the registered vector
module wb_port_ctrl
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 wren,
  output logic [AW-1:0]        rd_addr,
  output logic [XLEN-1:0]      reg_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        rs_addr1,
  input  logic [AW-1:0]        rs_addr2,
  output logic                 busy_rs1,
  output logic                 busy_rs2
);

  logic [NREQ-1:0] grant;
  logic            transfer;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  wb_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef WB_RR_ARB_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .req_valid (req_valid),
    .grant     (grant)
  );

  // Ready is forced low while reset is held, independent of the clock.
  assign req_ready = rst_n ? grant : '0;
  assign transfer  = |grant;

  // Grant is one-hot, so an OR of the gated slices selects the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | req_rd[i*AW +: AW];
        sel_data = sel_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are accepted but never reach the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren     <= 1'b0;
      rd_addr  <= '0;
      reg_data <= '0;
    end else begin
      wren <= transfer && (sel_rd != '0);
      if (transfer) begin
        rd_addr  <= sel_rd;
        reg_data <= sel_data;
      end
    end
  end

  // Clear first, then set, so an issue to the register committing this
  // cycle keeps it busy. Bit 0 can never be busy.
  always_comb begin
    busy_nxt = busy;
    if (wren)      busy_nxt[rd_addr] = 1'b0;
    if (iss_valid) busy_nxt[iss_rd]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_rs1 = busy[rs_addr1];
  assign busy_rs2 = busy[rs_addr2];

endmodule
